// File: rtl/bullet_scheduler.sv
// -----------------------------------------------------------------------------
// bullet_scheduler
//
// Shared bullet-slot controller for the two-player tank game. Takes level shoot
// requests from both players, arbitrates round-robin for a pool of NUM_SLOTS
// bullet slots, spawns a bullet at the shooter's tank centre, steps every live
// bullet once per game tick and retires bullets that leave the screen or that
// the collision logic reports as hit.
//
// Ports:
//   clk_i, reset_i            system clock, synchronous active-high reset
//   tick_i                    single-cycle game tick (movement + cooldown)
//   player_N_shoot_i          level shoot request per player
//   player_N_x_i/_y_i         tank upper-left corner per player (10 bits)
//   player_N_move_i           one-hot move: 0001 down, 0010 up, 0100 right,
//                             1000 left
//   hit_i, hit_slot_i         collision pulse and the slot it refers to
//   slot_valid_o              per-slot active flag
//   slot_owner_o              per-slot owner (0 = player 1, 1 = player 2)
//   slot_x_o, slot_y_o        packed positions, slot k at [10k+9:10k]
//   grant_o                   one-cycle grant pulse (bit0 p1, bit1 p2)
//   player_N_ready_o          high while that player's cooldown is zero
//
// Optional feature (macro BULLET_QUOTA_EN): when defined, each player may own
// at most NUM_SLOTS/2 live bullets; a player at quota is not eligible to shoot.
// -----------------------------------------------------------------------------
module bullet_scheduler #(
  parameter int NUM_SLOTS    = 4,
  parameter int COOLDOWN     = 16,
  parameter int BULLET_SPEED = 2,
  parameter int SLOT_W       = $clog2(NUM_SLOTS)
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    tick_i,
  input  logic                    player_1_shoot_i,
  input  logic                    player_2_shoot_i,
  input  logic [9:0]              player_1_x_i,
  input  logic [9:0]              player_1_y_i,
  input  logic [9:0]              player_2_x_i,
  input  logic [9:0]              player_2_y_i,
  input  logic [3:0]              player_1_move_i,
  input  logic [3:0]              player_2_move_i,
  input  logic                    hit_i,
  input  logic [SLOT_W-1:0]       hit_slot_i,
  output logic [NUM_SLOTS-1:0]    slot_valid_o,
  output logic [NUM_SLOTS-1:0]    slot_owner_o,
  output logic [NUM_SLOTS*10-1:0] slot_x_o,
  output logic [NUM_SLOTS*10-1:0] slot_y_o,
  output logic [1:0]              grant_o,
  output logic                    player_1_ready_o,
  output logic                    player_2_ready_o
);

  // +2 keeps the width at least one bit even when COOLDOWN is zero.
  localparam int              CD_W      = $clog2(COOLDOWN + 2);
  localparam logic [CD_W-1:0] CD_LOAD   = CD_W'(COOLDOWN);
  localparam logic [CD_W-1:0] CD_ONE    = CD_W'(1);
  localparam logic [9:0]      STEP      = 10'(BULLET_SPEED);
  localparam logic [10:0]     STEP_EXT  = 11'(BULLET_SPEED);
  localparam logic [10:0]     X_LIMIT   = 11'd640;
  localparam logic [10:0]     Y_LIMIT   = 11'd480;
  localparam logic [9:0]      SPAWN_OFS = 10'd15;
  localparam logic [3:0]      DIR_DOWN  = 4'b0001;
  localparam logic [3:0]      DIR_UP    = 4'b0010;
  localparam logic [3:0]      DIR_RIGHT = 4'b0100;
  localparam logic [3:0]      DIR_LEFT  = 4'b1000;

  typedef enum logic {
    RR_P1 = 1'b0,
    RR_P2 = 1'b1
  } rr_e;

  rr_e                  rr_q, rr_d;
  logic [NUM_SLOTS-1:0] slot_valid_q, slot_valid_d;
  logic [NUM_SLOTS-1:0] slot_owner_q, slot_owner_d;
  logic [9:0]           slot_x_q   [NUM_SLOTS];
  logic [9:0]           slot_x_d   [NUM_SLOTS];
  logic [9:0]           slot_y_q   [NUM_SLOTS];
  logic [9:0]           slot_y_d   [NUM_SLOTS];
  logic [3:0]           slot_dir_q [NUM_SLOTS];
  logic [3:0]           slot_dir_d [NUM_SLOTS];
  logic [CD_W-1:0]      cooldown_q [2];
  logic [CD_W-1:0]      cooldown_d [2];
  logic [3:0]           last_dir_q [2];
  logic [3:0]           last_dir_d [2];
  logic [1:0]           grant_q, grant_d;

  logic                 free_found;
  logic [SLOT_W-1:0]    free_idx;
  logic [1:0]           under_quota;
  logic [1:0]           eligible;
  logic [1:0]           win;

  // Lowest-index free slot, looked up on the registered valid vector so a slot
  // released this cycle only becomes allocatable next cycle.
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    for (int k = NUM_SLOTS - 1; k >= 0; k--) begin
      if (!slot_valid_q[k]) begin
        free_found = 1'b1;
        free_idx   = SLOT_W'(k);
      end
    end
  end

`ifdef BULLET_QUOTA_EN
  logic [SLOT_W:0] p1_owned, p2_owned;

  // Count live bullets per owner; a player at half the pool is held off.
  always_comb begin
    p1_owned = '0;
    p2_owned = '0;
    for (int k = 0; k < NUM_SLOTS; k++) begin
      if (slot_valid_q[k]) begin
        if (slot_owner_q[k]) p2_owned = p2_owned + (SLOT_W+1)'(1);
        else                 p1_owned = p1_owned + (SLOT_W+1)'(1);
      end
    end
    under_quota[0] = (p1_owned < (SLOT_W+1)'(NUM_SLOTS / 2));
    under_quota[1] = (p2_owned < (SLOT_W+1)'(NUM_SLOTS / 2));
  end
`else
  assign under_quota = 2'b11;
`endif

  // Round-robin arbitration: the pointer only moves when both players compete,
  // so a lone shooter never steals the other player's turn.
  always_comb begin
    eligible[0] = player_1_shoot_i && (cooldown_q[0] == '0) && free_found && under_quota[0];
    eligible[1] = player_2_shoot_i && (cooldown_q[1] == '0) && free_found && under_quota[1];
    rr_d = rr_q;
    win  = eligible;
    if (eligible == 2'b11) begin
      win  = (rr_q == RR_P1) ? 2'b01 : 2'b10;
      rr_d = (rr_q == RR_P1) ? RR_P2 : RR_P1;
    end
    grant_d = win;
  end

  // Slot update: hits take precedence over movement, retiring moves leave the
  // stored position untouched, and allocation only ever targets a slot that
  // was free before this edge, so it cannot collide with a hit or a move.
  always_comb begin
    slot_valid_d = slot_valid_q;
    slot_owner_d = slot_owner_q;
    slot_x_d     = slot_x_q;
    slot_y_d     = slot_y_q;
    slot_dir_d   = slot_dir_q;
    for (int k = 0; k < NUM_SLOTS; k++) begin
      if (slot_valid_q[k]) begin
        if (hit_i && (hit_slot_i == SLOT_W'(k))) begin
          slot_valid_d[k] = 1'b0;
        end else if (tick_i) begin
          case (slot_dir_q[k])
            DIR_DOWN: begin
              if (({1'b0, slot_y_q[k]} + STEP_EXT) >= Y_LIMIT) slot_valid_d[k] = 1'b0;
              else                                             slot_y_d[k] = slot_y_q[k] + STEP;
            end
            DIR_UP: begin
              if (slot_y_q[k] < STEP) slot_valid_d[k] = 1'b0;
              else                    slot_y_d[k] = slot_y_q[k] - STEP;
            end
            DIR_RIGHT: begin
              if (({1'b0, slot_x_q[k]} + STEP_EXT) >= X_LIMIT) slot_valid_d[k] = 1'b0;
              else                                             slot_x_d[k] = slot_x_q[k] + STEP;
            end
            DIR_LEFT: begin
              if (slot_x_q[k] < STEP) slot_valid_d[k] = 1'b0;
              else                    slot_x_d[k] = slot_x_q[k] - STEP;
            end
            default: ;
          endcase
        end
      end
    end
    if (win != 2'b00) begin
      slot_valid_d[free_idx] = 1'b1;
      slot_owner_d[free_idx] = win[1];
      slot_x_d[free_idx]     = win[1] ? (player_2_x_i + SPAWN_OFS) : (player_1_x_i + SPAWN_OFS);
      slot_y_d[free_idx]     = win[1] ? (player_2_y_i + SPAWN_OFS) : (player_1_y_i + SPAWN_OFS);
      slot_dir_d[free_idx]   = win[1] ? last_dir_q[1] : last_dir_q[0];
    end
  end

  // Cooldown reload beats the tick decrement, so a grant on a tick cycle still
  // starts from the full COOLDOWN. Direction memory ignores non-one-hot moves.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      cooldown_d[p] = cooldown_q[p];
      if (win[p])                              cooldown_d[p] = CD_LOAD;
      else if (tick_i && cooldown_q[p] != '0)  cooldown_d[p] = cooldown_q[p] - CD_ONE;
    end
    last_dir_d = last_dir_q;
    if ($onehot(player_1_move_i)) last_dir_d[0] = player_1_move_i;
    if ($onehot(player_2_move_i)) last_dir_d[1] = player_2_move_i;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rr_q          <= RR_P1;
      slot_valid_q  <= '0;
      slot_owner_q  <= '0;
      grant_q       <= '0;
      for (int k = 0; k < NUM_SLOTS; k++) begin
        slot_x_q[k]   <= '0;
        slot_y_q[k]   <= '0;
        slot_dir_q[k] <= '0;
      end
      cooldown_q[0] <= '0;
      cooldown_q[1] <= '0;
      last_dir_q[0] <= DIR_DOWN;
      last_dir_q[1] <= DIR_UP;
    end else begin
      rr_q          <= rr_d;
      slot_valid_q  <= slot_valid_d;
      slot_owner_q  <= slot_owner_d;
      grant_q       <= grant_d;
      for (int k = 0; k < NUM_SLOTS; k++) begin
        slot_x_q[k]   <= slot_x_d[k];
        slot_y_q[k]   <= slot_y_d[k];
        slot_dir_q[k] <= slot_dir_d[k];
      end
      cooldown_q[0] <= cooldown_d[0];
      cooldown_q[1] <= cooldown_d[1];
      last_dir_q[0] <= last_dir_d[0];
      last_dir_q[1] <= last_dir_d[1];
    end
  end

  for (genvar k = 0; k < NUM_SLOTS; k++) begin : g_pos
    assign slot_x_o[10*k +: 10] = slot_x_q[k];
    assign slot_y_o[10*k +: 10] = slot_y_q[k];
  end

  assign slot_valid_o     = slot_valid_q;
  assign slot_owner_o     = slot_owner_q;
  assign grant_o          = grant_q;
  assign player_1_ready_o = (cooldown_q[0] == '0);
  assign player_2_ready_o = (cooldown_q[1] == '0);

endmodule

// File: tb/tb_bullet_scheduler.sv
// -----------------------------------------------------------------------------
// tb_bullet_scheduler
//
// Directed scenarios for the bullet scheduler followed by a randomized run
// checked against a slot-pool model built from plain integer arithmetic.
// -----------------------------------------------------------------------------
module tb_bullet_scheduler;

  localparam int NUM_SLOTS    = 4;
  localparam int COOLDOWN     = 16;
  localparam int BULLET_SPEED = 2;
  localparam int SLOT_W       = 2;

  logic                    clk = 1'b0;
  logic                    reset_i, tick_i, hit_i;
  logic                    p1_shoot, p2_shoot;
  logic [9:0]              p1_x, p1_y, p2_x, p2_y;
  logic [3:0]              p1_move, p2_move;
  logic [SLOT_W-1:0]       hit_slot;
  logic [NUM_SLOTS-1:0]    slot_valid_o, slot_owner_o;
  logic [NUM_SLOTS*10-1:0] slot_x_o, slot_y_o;
  logic [1:0]              grant_o;
  logic                    p1_ready, p2_ready;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  bullet_scheduler #(
    .NUM_SLOTS(NUM_SLOTS), .COOLDOWN(COOLDOWN), .BULLET_SPEED(BULLET_SPEED)
  ) dut (
    .clk_i(clk), .reset_i(reset_i), .tick_i(tick_i),
    .player_1_shoot_i(p1_shoot), .player_2_shoot_i(p2_shoot),
    .player_1_x_i(p1_x), .player_1_y_i(p1_y),
    .player_2_x_i(p2_x), .player_2_y_i(p2_y),
    .player_1_move_i(p1_move), .player_2_move_i(p2_move),
    .hit_i(hit_i), .hit_slot_i(hit_slot),
    .slot_valid_o(slot_valid_o), .slot_owner_o(slot_owner_o),
    .slot_x_o(slot_x_o), .slot_y_o(slot_y_o),
    .grant_o(grant_o),
    .player_1_ready_o(p1_ready), .player_2_ready_o(p2_ready)
  );

  // Reference pool: directions are 0 down, 1 up, 2 right, 3 left.
  int m_valid [NUM_SLOTS];
  int m_owner [NUM_SLOTS];
  int m_x     [NUM_SLOTS];
  int m_y     [NUM_SLOTS];
  int m_dir   [NUM_SLOTS];
  int m_cd    [2];
  int m_last  [2];
  int m_rr;
  int m_grant;

  function automatic int onehot_index(input logic [3:0] mv);
    if ($countones(mv) != 1) return -1;
    for (int i = 0; i < 4; i++) if (mv[i]) return i;
    return -1;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NUM_SLOTS; k++) begin
      m_valid[k] = 0; m_owner[k] = 0; m_x[k] = 0; m_y[k] = 0; m_dir[k] = 0;
    end
    m_cd[0] = 0; m_cd[1] = 0;
    m_last[0] = 0; m_last[1] = 1;
    m_rr = 0;
    m_grant = 0;
  endtask

  task automatic model_step();
    int free_slot, win, nx, ny, mv;
    bit el0, el1;
    if (reset_i) begin
      model_reset();
      return;
    end
    free_slot = -1;
    for (int k = 0; k < NUM_SLOTS; k++) if (m_valid[k] == 0 && free_slot < 0) free_slot = k;
    el0 = p1_shoot && m_cd[0] == 0 && free_slot >= 0;
    el1 = p2_shoot && m_cd[1] == 0 && free_slot >= 0;
    win = -1;
    if (el0 && el1) begin
      win  = m_rr;
      m_rr = 1 - m_rr;
    end else if (el0) win = 0;
    else if (el1)     win = 1;
    for (int k = 0; k < NUM_SLOTS; k++) begin
      if (m_valid[k] != 0) begin
        if (hit_i && int'(hit_slot) == k) m_valid[k] = 0;
        else if (tick_i) begin
          nx = m_x[k] + ((m_dir[k] == 2) ? BULLET_SPEED : (m_dir[k] == 3) ? -BULLET_SPEED : 0);
          ny = m_y[k] + ((m_dir[k] == 0) ? BULLET_SPEED : (m_dir[k] == 1) ? -BULLET_SPEED : 0);
          if (nx < 0 || nx >= 640 || ny < 0 || ny >= 480) m_valid[k] = 0;
          else begin
            m_x[k] = nx;
            m_y[k] = ny;
          end
        end
      end
    end
    for (int p = 0; p < 2; p++) begin
      if (win == p)                     m_cd[p] = COOLDOWN;
      else if (tick_i && m_cd[p] > 0)   m_cd[p] = m_cd[p] - 1;
    end
    if (win >= 0) begin
      m_valid[free_slot] = 1;
      m_owner[free_slot] = win;
      m_x[free_slot]     = ((win == 0 ? int'(p1_x) : int'(p2_x)) + 15) % 1024;
      m_y[free_slot]     = ((win == 0 ? int'(p1_y) : int'(p2_y)) + 15) % 1024;
      m_dir[free_slot]   = m_last[win];
    end
    mv = onehot_index(p1_move); if (mv >= 0) m_last[0] = mv;
    mv = onehot_index(p2_move); if (mv >= 0) m_last[1] = mv;
    m_grant = win + 1;
  endtask

  // Inputs change only at the falling edge; outputs are read at the next one.
  task automatic drive_cycle();
    model_step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    reset_i = 1'b0; tick_i = 1'b0; hit_i = 1'b0; hit_slot = '0;
    p1_shoot = 1'b0; p2_shoot = 1'b0; p1_move = 4'b0000; p2_move = 4'b0000;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset_i = 1'b1;
    drive_cycle();
    reset_i = 1'b0;
  endtask

  task automatic test_reset();
    p1_shoot = 1'b1; p2_shoot = 1'b1; tick_i = 1'b1;
    reset_i = 1'b1;
    drive_cycle();
    idle_inputs();
    total++; if (slot_valid_o !== 4'b0000) begin bad++; $display("[TB] FAIL reset_valid: got %b want 0000", slot_valid_o); end
    total++; if (grant_o !== 2'b00) begin bad++; $display("[TB] FAIL reset_grant: got %b want 00", grant_o); end
    total++; if ({p1_ready, p2_ready} !== 2'b11) begin bad++; $display("[TB] FAIL reset_ready: got %b want 11", {p1_ready, p2_ready}); end
    total++; if (slot_owner_o !== 4'b0000) begin bad++; $display("[TB] FAIL reset_owner: got %b want 0000", slot_owner_o); end
  endtask

  task automatic test_single_shot();
    do_reset();
    p1_x = 10'd224; p1_y = 10'd64; p1_move = 4'b0001; p1_shoot = 1'b1;
    drive_cycle();
    p1_shoot = 1'b0;
    total++; if (grant_o !== 2'b01) begin bad++; $display("[TB] FAIL shot_grant: got %b want 01", grant_o); end
    total++; if (slot_valid_o !== 4'b0001) begin bad++; $display("[TB] FAIL shot_valid: got %b want 0001", slot_valid_o); end
    total++; if (slot_owner_o[0] !== 1'b0) begin bad++; $display("[TB] FAIL shot_owner: got %b want 0", slot_owner_o[0]); end
    total++; if (slot_x_o[9:0] !== 10'd239) begin bad++; $display("[TB] FAIL shot_x: got %0d want 239", slot_x_o[9:0]); end
    total++; if (slot_y_o[9:0] !== 10'd79) begin bad++; $display("[TB] FAIL shot_y: got %0d want 79", slot_y_o[9:0]); end
    total++; if (p1_ready !== 1'b0) begin bad++; $display("[TB] FAIL shot_ready: got %b want 0", p1_ready); end
    tick_i = 1'b1;
    repeat (3) drive_cycle();
    total++; if (grant_o !== 2'b00) begin bad++; $display("[TB] FAIL shot_pulse: got %b want 00", grant_o); end
    total++; if (slot_y_o[9:0] !== 10'd85) begin bad++; $display("[TB] FAIL shot_move_y: got %0d want 85", slot_y_o[9:0]); end
    repeat (12) drive_cycle();
    total++; if (p1_ready !== 1'b0) begin bad++; $display("[TB] FAIL ready_15: got %b want 0", p1_ready); end
    drive_cycle();
    total++; if (p1_ready !== 1'b1) begin bad++; $display("[TB] FAIL ready_16: got %b want 1", p1_ready); end
    idle_inputs();
  endtask

  task automatic test_both_shoot();
    do_reset();
    p1_x = 10'd100; p1_y = 10'd100; p1_move = 4'b0100;
    p2_x = 10'd300; p2_y = 10'd200; p2_move = 4'b1000;
    drive_cycle();
    p1_shoot = 1'b1; p2_shoot = 1'b1;
    drive_cycle();
    total++; if (grant_o !== 2'b01) begin bad++; $display("[TB] FAIL both_first: got %b want 01", grant_o); end
    drive_cycle();
    total++; if (grant_o !== 2'b10) begin bad++; $display("[TB] FAIL both_second: got %b want 10", grant_o); end
    total++; if (slot_owner_o[1:0] !== 2'b10) begin bad++; $display("[TB] FAIL both_owner: got %b want 10", slot_owner_o[1:0]); end
    p1_shoot = 1'b0; p2_shoot = 1'b0; tick_i = 1'b1;
    repeat (16) drive_cycle();
    tick_i = 1'b0;
    total++; if ({p1_ready, p2_ready} !== 2'b11) begin bad++; $display("[TB] FAIL both_ready: got %b want 11", {p1_ready, p2_ready}); end
    p1_shoot = 1'b1; p2_shoot = 1'b1;
    drive_cycle();
    total++; if (grant_o !== 2'b10) begin bad++; $display("[TB] FAIL both_rr_turn: got %b want 10", grant_o); end
    total++; if (slot_valid_o !== 4'b0111) begin bad++; $display("[TB] FAIL both_valid: got %b want 0111", slot_valid_o); end
    drive_cycle();
    total++; if (grant_o !== 2'b01) begin bad++; $display("[TB] FAIL both_rr_next: got %b want 01", grant_o); end
    idle_inputs();
  endtask

  task automatic test_underflow();
    do_reset();
    p2_x = 10'd224; p2_y = 10'd416; p2_move = 4'b0010;
    drive_cycle();
    p2_shoot = 1'b1;
    drive_cycle();
    p2_shoot = 1'b0;
    total++; if (slot_y_o[9:0] !== 10'd431 || slot_owner_o[0] !== 1'b1) begin bad++; $display("[TB] FAIL uf_spawn: got y=%0d own=%b want y=431 own=1", slot_y_o[9:0], slot_owner_o[0]); end
    tick_i = 1'b1;
    repeat (215) drive_cycle();
    total++; if (slot_valid_o[0] !== 1'b1 || slot_y_o[9:0] !== 10'd1) begin bad++; $display("[TB] FAIL uf_last_step: got v=%b y=%0d want v=1 y=1", slot_valid_o[0], slot_y_o[9:0]); end
    drive_cycle();
    total++; if (slot_valid_o[0] !== 1'b0 || slot_y_o[9:0] !== 10'd1) begin bad++; $display("[TB] FAIL uf_retire: got v=%b y=%0d want v=0 y=1", slot_valid_o[0], slot_y_o[9:0]); end
    repeat (24) drive_cycle();
    total++; if (slot_valid_o !== 4'b0000) begin bad++; $display("[TB] FAIL uf_after: got %b want 0000", slot_valid_o); end
    idle_inputs();
  endtask

  task automatic test_pool_full();
    int grants;
    do_reset();
    p1_x = 10'd200; p1_y = 10'd100; p1_move = 4'b0100;
    p2_x = 10'd300; p2_y = 10'd300; p2_move = 4'b0100;
    drive_cycle();
    p1_shoot = 1'b1; p2_shoot = 1'b1; tick_i = 1'b1;
    grants = 0;
    for (int c = 0; c < 40; c++) begin
      drive_cycle();
      if (grant_o != 2'b00) grants++;
    end
    tick_i = 1'b0;
    total++; if (grants != 4) begin bad++; $display("[TB] FAIL full_grants: got %0d want 4", grants); end
    total++; if (slot_valid_o !== 4'b1111 || slot_owner_o !== 4'b1010) begin bad++; $display("[TB] FAIL full_pool: got v=%b o=%b want v=1111 o=1010", slot_valid_o, slot_owner_o); end
    for (int c = 0; c < 3; c++) begin
      drive_cycle();
      total++; if (grant_o !== 2'b00) begin bad++; $display("[TB] FAIL full_stall: got %b want 00", grant_o); end
    end
    hit_i = 1'b1; hit_slot = 2'd2;
    drive_cycle();
    hit_i = 1'b0;
    total++; if (slot_valid_o !== 4'b1011 || grant_o !== 2'b00) begin bad++; $display("[TB] FAIL full_hit: got v=%b g=%b want v=1011 g=00", slot_valid_o, grant_o); end
    drive_cycle();
    total++; if (grant_o !== 2'b10 || slot_valid_o !== 4'b1111 || slot_owner_o[2] !== 1'b1) begin bad++; $display("[TB] FAIL full_realloc: got g=%b v=%b o=%b want g=10 v=1111 o2=1", grant_o, slot_valid_o, slot_owner_o); end
    idle_inputs();
  endtask

  task automatic test_hit_tick();
    do_reset();
    p1_x = 10'd224; p1_y = 10'd64; p1_move = 4'b0001;
    drive_cycle();
    p1_shoot = 1'b1;
    drive_cycle();
    p1_shoot = 1'b0; hit_i = 1'b1; hit_slot = 2'd0; tick_i = 1'b1;
    drive_cycle();
    hit_i = 1'b0; tick_i = 1'b0;
    total++; if (slot_valid_o[0] !== 1'b0 || slot_y_o[9:0] !== 10'd79 || slot_x_o[9:0] !== 10'd239) begin bad++; $display("[TB] FAIL hit_tick: got v=%b x=%0d y=%0d want v=0 x=239 y=79", slot_valid_o[0], slot_x_o[9:0], slot_y_o[9:0]); end
    idle_inputs();
  endtask

  task automatic test_grant_tick();
    do_reset();
    p1_x = 10'd50; p1_y = 10'd60; p1_move = 4'b0100;
    drive_cycle();
    p1_shoot = 1'b1; tick_i = 1'b1;
    drive_cycle();
    p1_shoot = 1'b0;
    total++; if (slot_x_o[9:0] !== 10'd65 || grant_o !== 2'b01) begin bad++; $display("[TB] FAIL gt_spawn: got x=%0d g=%b want x=65 g=01", slot_x_o[9:0], grant_o); end
    repeat (15) drive_cycle();
    total++; if (p1_ready !== 1'b0 || slot_x_o[9:0] !== 10'd95) begin bad++; $display("[TB] FAIL gt_cd15: got rdy=%b x=%0d want rdy=0 x=95", p1_ready, slot_x_o[9:0]); end
    drive_cycle();
    total++; if (p1_ready !== 1'b1) begin bad++; $display("[TB] FAIL gt_cd16: got %b want 1", p1_ready); end
    idle_inputs();
  endtask

  task automatic test_reset_midflight();
    do_reset();
    p1_x = 10'd100; p1_y = 10'd100; p2_x = 10'd200; p2_y = 10'd200;
    p1_shoot = 1'b1; p2_shoot = 1'b1;
    repeat (2) drive_cycle();
    reset_i = 1'b1;
    drive_cycle();
    reset_i = 1'b0;
    total++; if (slot_valid_o !== 4'b0000 || grant_o !== 2'b00) begin bad++; $display("[TB] FAIL mid_reset: got v=%b g=%b want v=0000 g=00", slot_valid_o, grant_o); end
    total++; if ({p1_ready, p2_ready} !== 2'b11 || slot_x_o !== '0 || slot_y_o !== '0) begin bad++; $display("[TB] FAIL mid_clear: got rdy=%b x=%h y=%h want rdy=11 x=0 y=0", {p1_ready, p2_ready}, slot_x_o, slot_y_o); end
    drive_cycle();
    total++; if (grant_o !== 2'b01) begin bad++; $display("[TB] FAIL mid_rr: got %b want 01", grant_o); end
    idle_inputs();
  endtask

  task automatic test_random();
    logic [NUM_SLOTS-1:0] exp_valid;
    logic [1:0]           exp_grant;
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      reset_i  = ($urandom_range(0, 299) == 0);
      tick_i   = ($urandom_range(0, 9) < 4);
      p1_shoot = $urandom_range(0, 1) == 1;
      p2_shoot = $urandom_range(0, 1) == 1;
      hit_i    = ($urandom_range(0, 9) == 0);
      hit_slot = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) begin
        p1_x = 10'($urandom_range(0, 620)); p1_y = 10'($urandom_range(0, 460));
        p2_x = 10'($urandom_range(0, 620)); p2_y = 10'($urandom_range(0, 460));
      end
      p1_move = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(0, 15)) : 4'(1 << $urandom_range(0, 3));
      p2_move = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(0, 15)) : 4'(1 << $urandom_range(0, 3));
      drive_cycle();
      for (int k = 0; k < NUM_SLOTS; k++) exp_valid[k] = (m_valid[k] != 0);
      exp_grant = (m_grant == 1) ? 2'b01 : (m_grant == 2) ? 2'b10 : 2'b00;
      total++; if (slot_valid_o !== exp_valid) begin bad++; $display("[TB] FAIL rnd_valid c=%0d: got %b want %b", c, slot_valid_o, exp_valid); end
      total++; if (grant_o !== exp_grant) begin bad++; $display("[TB] FAIL rnd_grant c=%0d: got %b want %b", c, grant_o, exp_grant); end
      total++; if ({p2_ready, p1_ready} !== {m_cd[1] == 0, m_cd[0] == 0}) begin bad++; $display("[TB] FAIL rnd_ready c=%0d: got %b want %b", c, {p2_ready, p1_ready}, {m_cd[1] == 0, m_cd[0] == 0}); end
      for (int k = 0; k < NUM_SLOTS; k++) begin
        if (m_valid[k] != 0) begin
          total++;
          if (slot_owner_o[k] !== 1'(m_owner[k]) || slot_x_o[10*k +: 10] !== 10'(m_x[k]) || slot_y_o[10*k +: 10] !== 10'(m_y[k])) begin
            bad++;
            $display("[TB] FAIL rnd_slot%0d c=%0d: got o=%b x=%0d y=%0d want o=%0d x=%0d y=%0d", k, c,
                     slot_owner_o[k], slot_x_o[10*k +: 10], slot_y_o[10*k +: 10], m_owner[k], m_x[k], m_y[k]);
          end
        end
      end
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    p1_x = '0; p1_y = '0; p2_x = '0; p2_y = '0;
    model_reset();
    @(negedge clk);
    test_reset();
    test_single_shot();
    test_both_shoot();
    test_underflow();
    test_pool_full();
    test_hit_tick();
    test_grant_tick();
    test_reset_midflight();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
